shift_unit_iter: RTL and testbench

Iterative 32-bit shift unit for the ALU's shift ops (SLL, SRA). It decomposes a 5-bit shift amount into fixed stages of 16/8/4/2/1 and applies at most one stage per clock, so the 32-bit shift logic is a single stage rather than a full combinational barrel. It sits between the ALU operand latch (upstream, valid/ready) and the writeback mux (downstream, valid/ready). The ALU routes shift ops here instead of through a combinational barrel shifter.

---
 rtl/shift_unit_iter_if.sv | 26 ++
 rtl/shift_unit_iter.sv | 136 +++++++++++++
 tb/tb_shift_unit_iter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/shift_unit_iter_if.sv
// Operand/result handshake bundle between the ALU operand latch, the iterative
// shift unit and the writeback mux.
interface shift_unit_iter_if;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_a;
  logic [SW-1:0] shamt;
  logic          op_sra;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          busy;

  modport master (
    output in_valid, data_a, shamt, op_sra, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, data_a, shamt, op_sra, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/shift_unit_iter.sv
// Iterative 32-bit SLL/SRA unit: applies one fixed 16/8/4/2/1 stage per clock,
// optionally stopping once the remaining shift-amount bits are all zero.
module shift_unit_iter #(
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  shift_unit_iter_if.slave   bus
);

  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = 5;
  localparam int unsigned STW = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic EE = (EARLY_EXIT != 0);

  logic [1:0]     r_state;
  logic [DW-1:0]  r_acc;
  logic [SW-1:0]  r_sh;
  logic           r_sra;
  logic [STW-1:0] r_step;

  logic [1:0]     w_state_nxt;
  logic [DW-1:0]  w_acc_nxt;
  logic [SW-1:0]  w_sh_nxt;
  logic           w_sra_nxt;
  logic [STW-1:0] w_step_nxt;

  logic [DW-1:0]  w_stage;
  logic           w_bit;
  logic           w_low_zero;

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_sh    <= '0;
      r_sra   <= 1'b0;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_sh    <= w_sh_nxt;
      r_sra   <= w_sra_nxt;
      r_step  <= w_step_nxt;
    end
  end

  // Single shift stage selected by step; bit index is 4-step
  always_comb begin
    w_stage    = r_acc;
    w_bit      = 1'b0;
    w_low_zero = 1'b1;
    case (r_step)
      3'd0: begin
        w_stage    = r_sra ? {{16{r_acc[31]}}, r_acc[31:16]} : {r_acc[15:0], 16'b0};
        w_bit      = r_sh[4];
        w_low_zero = (r_sh[3:0] == 4'd0);
      end
      3'd1: begin
        w_stage    = r_sra ? {{8{r_acc[31]}}, r_acc[31:8]} : {r_acc[23:0], 8'b0};
        w_bit      = r_sh[3];
        w_low_zero = (r_sh[2:0] == 3'd0);
      end
      3'd2: begin
        w_stage    = r_sra ? {{4{r_acc[31]}}, r_acc[31:4]} : {r_acc[27:0], 4'b0};
        w_bit      = r_sh[2];
        w_low_zero = (r_sh[1:0] == 2'd0);
      end
      3'd3: begin
        w_stage    = r_sra ? {{2{r_acc[31]}}, r_acc[31:2]} : {r_acc[29:0], 2'b0};
        w_bit      = r_sh[1];
        w_low_zero = (r_sh[0] == 1'b0);
      end
      3'd4: begin
        w_stage    = r_sra ? {r_acc[31], r_acc[31:1]} : {r_acc[30:0], 1'b0};
        w_bit      = r_sh[0];
        w_low_zero = 1'b1;
      end
      default: begin
        w_stage    = r_acc;
        w_bit      = 1'b0;
        w_low_zero = 1'b1;
      end
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_sh_nxt    = r_sh;
    w_sra_nxt   = r_sra;
    w_step_nxt  = r_step;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_acc_nxt   = bus.data_a;
          w_sh_nxt    = bus.shamt;
          w_sra_nxt   = bus.op_sra;
          w_step_nxt  = '0;
          w_state_nxt = (EE && (bus.shamt == 5'd0)) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_bit) begin
          w_acc_nxt = w_stage;
        end
        if ((r_step == 3'd4) || (EE && w_low_zero)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_step_nxt = r_step + 3'd1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.result    = r_acc;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Directed bench: drives an early-exit and a fixed-latency instance with the
// same operands and checks results, latency, handshake and reset behaviour.
module tb_shift_unit_iter;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  shift_unit_iter_if if_e ();
  shift_unit_iter_if if_f ();

  shift_unit_iter #(.EARLY_EXIT(1)) dut_e (.clock(clock), .reset_n(reset_n), .bus(if_e));
  shift_unit_iter #(.EARLY_EXIT(0)) dut_f (.clock(clock), .reset_n(reset_n), .bus(if_f));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [4:0] sh, input logic sra);
    if_e.in_valid = v; if_e.data_a = a; if_e.shamt = sh; if_e.op_sra = sra;
    if_f.in_valid = v; if_f.data_a = a; if_f.shamt = sh; if_f.op_sra = sra;
  endtask

  task automatic set_ordy(input logic r);
    if_e.out_ready = r;
    if_f.out_ready = r;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_irdy_e"}, 32'(if_e.in_ready), 32'd1);
    chk({tag, "_irdy_f"}, 32'(if_f.in_ready), 32'd1);
    chk({tag, "_oval_e"}, 32'(if_e.out_valid), 32'd0);
    chk({tag, "_oval_f"}, 32'(if_f.out_valid), 32'd0);
  endtask

  // Accept one operand at E0, wait for both units, check result and latency
  task automatic do_op(input string tag, input logic [31:0] a, input logic [4:0] sh,
                       input logic sra, input logic [31:0] exp_res, input int exp_lat_e,
                       input logic release_it);
    int  lat_e;
    int  lat_f;
    int  n;
    int  viol;
    bit  done_e;
    bit  done_f;
    lat_e = 99; lat_f = 99; n = 0; viol = 0; done_e = 0; done_f = 0;
    set_ordy(1'b0);
    drive(1'b1, a, sh, sra);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    while (!(done_e && done_f) && n <= 20) begin
      if (if_e.in_ready || if_f.in_ready) viol++;
      if (!done_e && if_e.out_valid) begin lat_e = n; done_e = 1; end
      if (!done_f && if_f.out_valid) begin lat_f = n; done_f = 1; end
      if (!(done_e && done_f)) begin
        tick();
        n++;
      end
    end
    chk({tag, "_lat_e"}, 32'(lat_e), 32'(exp_lat_e));
    chk({tag, "_lat_f"}, 32'(lat_f), 32'd5);
    chk({tag, "_res_e"}, if_e.result, exp_res);
    chk({tag, "_res_f"}, if_f.result, exp_res);
    chk({tag, "_irdy_low"}, 32'(viol), 32'd0);
    chk({tag, "_busy"}, {30'd0, if_e.busy, if_f.busy}, 32'd3);
    if (release_it) begin
      set_ordy(1'b1);
      tick();
      set_ordy(1'b0);
      chk_idle({tag, "_post"});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    set_ordy(1'b0);
    tick();
    tick();
    // Reset state
    chk_idle("rst");
    chk("rst_res_e", if_e.result, 32'h0);
    chk("rst_busy_f", 32'(if_f.busy), 32'd0);
    #3 reset_n = 1'b1;
    tick();

    do_op("sra8",   32'h8000_0000, 5'd8,  1'b1, 32'hFF80_0000, 2, 1'b1);
    do_op("sll31",  32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, 5, 1'b1);
    do_op("sll4",   32'h0000_FFFF, 5'd4,  1'b0, 32'h000F_FFF0, 3, 1'b1);
    do_op("zero",   32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 0, 1'b1);
    do_op("sra0",   32'h8765_4321, 5'd0,  1'b1, 32'h8765_4321, 0, 1'b1);

    // Backpressure: hold DONE while a new operand is offered
    do_op("bp", 32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000, 5, 1'b0);
    drive(1'b1, 32'hDEAD_BEEF, 5'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_oval_e", 32'(if_e.out_valid), 32'd1);
      chk("bp_hold_oval_f", 32'(if_f.out_valid), 32'd1);
      chk("bp_hold_res_e", if_e.result, 32'h0);
      chk("bp_hold_irdy", {30'd0, if_e.in_ready, if_f.in_ready}, 32'd0);
    end
    set_ordy(1'b1);
    tick();
    set_ordy(1'b0);
    chk("bp_rel_irdy", {30'd0, if_e.in_ready, if_f.in_ready}, 32'd3);
    chk("bp_rel_res_e", if_e.result, 32'h0);
    do_op("bp_new", 32'hDEAD_BEEF, 5'd4, 1'b0, 32'hEADB_EEF0, 3, 1'b1);

    // Asynchronous reset between E2 and E3
    drive(1'b1, 32'h0000_0001, 5'd1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_res_e", if_e.result, 32'h0);
    chk("mid_rst_res_f", if_f.result, 32'h0);
    chk("mid_rst_busy", {30'd0, if_e.busy, if_f.busy}, 32'd0);
    #2 reset_n = 1'b1;
    tick();
    chk_idle("after_rst");
    do_op("sll2", 32'h0000_0003, 5'd2, 1'b0, 32'h0000_000C, 4, 1'b1);

    // Back-to-back with no leakage of direction or accumulator
    do_op("b2b_sra", 32'hF000_0000, 5'd16, 1'b1, 32'hFFFF_F000, 1, 1'b1);
    do_op("b2b_sll", 32'h0000_0001, 5'd1,  1'b0, 32'h0000_0002, 5, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
